cut_bist_controller: RTL and testbench

- Built-in self-test sequencer and access arbiter for one 32-in/32-out combinational benchmark circuit (CUT).
- In functional mode it passes system inputs straight to the CUT.
- On a start request it takes the CUT, applies LFSR pseudo-random patterns, and compacts the CUT responses into a MISR signature.
- It then reports the signature and a pass/fail result against a golden value. It sits between the benchmark netlist and the system or test harness.

---
 rtl/cut_bist_pkg.sv | 22 ++
 rtl/lfsr_misr_core.sv | 31 +++
 rtl/cut_bist_controller.sv | 144 ++++++++++++++
 tb/tb_cut_bist_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cut_bist_pkg.sv
// Shared definitions for the CUT BIST controller: FSM states, default feedback taps
// and the Galois shift step used by both the pattern generator and the signature register.
package cut_bist_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] DEFAULT_TAPS = 32'h0040_0007;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Galois-form shift: bits that fall off the top feed back through the tap mask.
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] taps);
    return {x[DATA_W-2:0], 1'b0} ^ (x[DATA_W-1] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_misr_core.sv
// Shift register with load, clear and step-enable; xor_in folds a response word into each step.
// Tie xor_in to zero for a plain LFSR, drive it with CUT outputs for a MISR.
module lfsr_misr_core
  import cut_bist_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter logic [WIDTH-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             step_en,
  input  logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (clear) begin
      q <= '0;
    end else if (step_en) begin
      q <= step(q, TAPS) ^ xor_in;
    end
  end

endmodule

// File: rtl/cut_bist_controller.sv
// BIST sequencer and CUT access mux: seeds an LFSR, applies N_PATTERNS patterns held SETTLE
// cycles each, compacts responses into a MISR and reports pass against GOLDEN.
module cut_bist_controller
  import cut_bist_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_PATTERNS = 1024,
  parameter int SETTLE = 1,
  parameter logic [WIDTH-1:0] SEED = 32'h0000_0001,
  parameter logic [WIDTH-1:0] GOLDEN = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] func_in,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] cut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      pattern_cnt
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [16:0] N_LAST = 17'(N_PATTERNS);

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] misr_q;
  logic [SCW-1:0]   settle_cnt;
  logic [15:0]      cnt_q;
  logic [16:0]      cnt_inc;
  logic             seeding;
  logic             capturing;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] misr_next;

  // Abort gates the datapath so the signature stays frozen for debug.
  assign seeding   = (state == ST_SEED) && !abort;
  assign capturing = (state == ST_CAPTURE) && !abort;
  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
  assign lfsr_next = step(lfsr_q, TAPS);
  assign misr_next = step(misr_q, TAPS) ^ cut_out;

  lfsr_misr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seeding),
    .load_val (SEED_EFF),
    .clear    (1'b0),
    .step_en  (capturing),
    .xor_in   ('0),
    .q        (lfsr_q)
  );

  lfsr_misr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .clear    (seeding),
    .step_en  (capturing),
    .xor_in   (cut_out),
    .q        (misr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pat        <= '0;
      settle_cnt <= '0;
      cnt_q      <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SEED;
            busy  <= 1'b1;
          end
        end
        ST_SEED: begin
          state      <= ST_APPLY;
          pat        <= SEED_EFF;
          settle_cnt <= '0;
          cnt_q      <= '0;
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          cnt_q      <= cnt_inc[15:0];
          settle_cnt <= '0;
          if (cnt_inc == N_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_next == GOLDEN);
          end else begin
            state <= ST_APPLY;
            pat   <= lfsr_next;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_SEED;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

  assign cut_in      = busy ? pat : func_in;
  assign signature   = misr_q;
  assign pattern_cnt = cnt_q;

endmodule

// File: tb/tb_cut_bist_controller.sv
// Directed bench for cut_bist_controller: four instances with different seeds/lengths,
// a per-cycle vector table for the loopback run, and hand sequences for abort/restart/reset.
module tb_cut_bist_controller;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] func_in;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // a: loopback, N=3, SEED=1
  logic a_start, a_abort, a_busy, a_done, a_pass;
  logic [31:0] a_cut_in, a_sig;
  logic [15:0] a_cnt;
  // w: loopback, SEED=8000_0000, N=2
  logic w_start, w_abort, w_busy, w_done, w_pass;
  logic [31:0] w_cut_in, w_sig;
  logic [15:0] w_cnt;
  // z: zero response, N=4
  logic z_start, z_abort, z_busy, z_done, z_pass;
  logic [31:0] z_cut_in, z_sig;
  logic [15:0] z_cnt;
  // s: loopback, SEED=0 (promoted to 1), N=3
  logic s_start, s_abort, s_busy, s_done, s_pass;
  logic [31:0] s_cut_in, s_sig;
  logic [15:0] s_cnt;

  cut_bist_controller #(.N_PATTERNS(3), .SETTLE(1), .SEED(32'h1), .GOLDEN(32'h0)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .func_in(func_in),
    .cut_out(a_cut_in), .cut_in(a_cut_in), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_sig), .pattern_cnt(a_cnt));

  cut_bist_controller #(.N_PATTERNS(2), .SETTLE(1), .SEED(32'h8000_0000), .GOLDEN(32'h0)) u_w (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .func_in(func_in),
    .cut_out(w_cut_in), .cut_in(w_cut_in), .busy(w_busy), .done(w_done), .pass(w_pass),
    .signature(w_sig), .pattern_cnt(w_cnt));

  cut_bist_controller #(.N_PATTERNS(4), .SETTLE(1), .SEED(32'h1), .GOLDEN(32'h0)) u_z (
    .clk(clk), .rst(rst), .start(z_start), .abort(z_abort), .func_in(func_in),
    .cut_out(32'h0), .cut_in(z_cut_in), .busy(z_busy), .done(z_done), .pass(z_pass),
    .signature(z_sig), .pattern_cnt(z_cnt));

  cut_bist_controller #(.N_PATTERNS(3), .SETTLE(1), .SEED(32'h0), .GOLDEN(32'h0)) u_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .func_in(func_in),
    .cut_out(s_cut_in), .cut_in(s_cut_in), .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_sig), .pattern_cnt(s_cnt));

  typedef struct {
    logic [31:0] cut_in;
    logic [31:0] sig;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        pass;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Loopback run, rows indexed by cycles after the start edge (sampled #1 after each edge).
    tbl[0] = '{32'h0,         32'h0, 16'd0, 1'b1, 1'b0, 1'b0}; // SEED
    tbl[1] = '{32'h1,         32'h0, 16'd0, 1'b1, 1'b0, 1'b0}; // APPLY p1
    tbl[2] = '{32'h1,         32'h0, 16'd0, 1'b1, 1'b0, 1'b0}; // CAPTURE p1
    tbl[3] = '{32'h2,         32'h1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h2,         32'h1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h4,         32'h0, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h4,         32'h0, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'hCAFE_0000, 32'h4, 16'd3, 1'b0, 1'b1, 1'b0}; // DONE

    rst = 1'b1;
    func_in = 32'hDEAD_BEEF;
    {a_start, a_abort, w_start, w_abort, z_start, z_abort, s_start, s_abort} = '0;
    #12;
    chk("rst_cut_in", 0, a_cut_in, 32'hDEAD_BEEF);
    chk("rst_busy", 0, {31'b0, a_busy}, 32'h0);
    chk("rst_done", 0, {31'b0, a_done}, 32'h0);
    chk("rst_sig", 0, a_sig, 32'h0);
    chk("rst_cnt", 0, {16'b0, a_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_cut_in", 0, a_cut_in, 32'hDEAD_BEEF);
    func_in = 32'hCAFE_0000;

    // All four instances start on the same edge.
    a_start = 1'b1; w_start = 1'b1; z_start = 1'b1; s_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        a_start = 1'b0; w_start = 1'b0; z_start = 1'b0; s_start = 1'b0;
      end
      if (k == 2) s_start = 1'b1;   // lands on a busy cycle: must be ignored
      if (k == 3) s_start = 1'b0;
      chk("a_cut_in", k, a_cut_in, tbl[k].cut_in);
      chk("a_sig", k, a_sig, tbl[k].sig);
      chk("a_cnt", k, {16'b0, a_cnt}, {16'b0, tbl[k].cnt});
      chk("a_busy", k, {31'b0, a_busy}, {31'b0, tbl[k].busy});
      chk("a_done", k, {31'b0, a_done}, {31'b0, tbl[k].done});
      if (tbl[k].done) chk("a_pass", k, {31'b0, a_pass}, {31'b0, tbl[k].pass});
      if (k == 1) chk("w_pat0", k, w_cut_in, 32'h8000_0000);
      if (k == 3) chk("w_pat1", k, w_cut_in, 32'h0040_0007);
      if (k == 5) begin
        chk("w_done", k, {31'b0, w_done}, 32'h1);
        chk("w_sig", k, w_sig, 32'h0);
        chk("w_pass", k, {31'b0, w_pass}, 32'h1);
      end
      if (k == 1) chk("s_pat0", k, s_cut_in, 32'h1);
      if (k == 7) begin
        chk("z_not_done", k, {31'b0, z_done}, 32'h0);
        chk("s_done", k, {31'b0, s_done}, 32'h1);
        chk("s_sig", k, s_sig, 32'h4);
      end
    end
    tick();
    tick();
    chk("z_done", 9, {31'b0, z_done}, 32'h1);
    chk("z_sig", 9, z_sig, 32'h0);
    chk("z_pass", 9, {31'b0, z_pass}, 32'h1);
    chk("z_cnt", 9, {16'b0, z_cnt}, 32'd4);
    chk("a_hold_sig", 9, a_sig, 32'h4);

    // Restart s from DONE: MISR clears and the run repeats.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("s_re_busy", 0, {31'b0, s_busy}, 32'h1);
    chk("s_re_done", 0, {31'b0, s_done}, 32'h0);
    tick();
    chk("s_re_sig_clr", 1, s_sig, 32'h0);
    chk("s_re_pat0", 1, s_cut_in, 32'h1);
    for (int k = 2; k < 8; k++) tick();
    chk("s_re_done7", 7, {31'b0, s_done}, 32'h1);
    chk("s_re_sig", 7, s_sig, 32'h4);
    chk("s_re_cnt", 7, {16'b0, s_cnt}, 32'd3);

    // Abort a mid-run together with a start pulse.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    chk("a_pre_abort_cnt", 5, {16'b0, a_cnt}, 32'd2);
    chk("a_pre_abort_busy", 5, {31'b0, a_busy}, 32'h1);
    a_abort = 1'b1;
    a_start = 1'b1;
    tick();
    a_abort = 1'b0;
    a_start = 1'b0;
    chk("ab_busy", 6, {31'b0, a_busy}, 32'h0);
    chk("ab_done", 6, {31'b0, a_done}, 32'h0);
    chk("ab_cut_in", 6, a_cut_in, 32'hCAFE_0000);
    chk("ab_cnt", 6, {16'b0, a_cnt}, 32'd2);
    for (int k = 0; k < 3; k++) tick();
    chk("ab_stay_idle", 9, {31'b0, a_busy}, 32'h0);
    chk("ab_cnt_hold", 9, {16'b0, a_cnt}, 32'd2);

    // Reset mid-run on w clears immediately and nothing resumes.
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    chk("w_pre_rst_cnt", 3, {16'b0, w_cnt}, 32'd1);
    chk("w_pre_rst_sig", 3, w_sig, 32'h8000_0000);
    rst = 1'b1;
    #1;
    chk("w_rst_busy", 0, {31'b0, w_busy}, 32'h0);
    chk("w_rst_sig", 0, w_sig, 32'h0);
    chk("w_rst_cnt", 0, {16'b0, w_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("w_no_resume_busy", 5, {31'b0, w_busy}, 32'h0);
    chk("w_no_resume_done", 5, {31'b0, w_done}, 32'h0);
    chk("w_no_resume_cut", 5, w_cut_in, 32'hCAFE_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
